// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared types and helpers for the BCD score bank.
//   BCD_W / BCD_MAX : width and largest legal value of one decimal digit
//   MAX_DIGITS      : widest counter the bank supports (sizes dec_to_bcd)
//   score_state_t   : game FSM states
//   dec_to_bcd()    : integer -> packed BCD, units digit in the low nibble
// ---------------------------------------------------------------------------
package score_pkg;

    localparam int              BCD_W      = 4;
    localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
    localparam int              MAX_DIGITS = 4;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } score_state_t;

    // Used at elaboration to turn the decimal win threshold into the same
    // packed form the digit chains produce, so the compare is a plain equality.
    function automatic logic [MAX_DIGITS*BCD_W-1:0] dec_to_bcd(input int value);
        logic [MAX_DIGITS*BCD_W-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            r[d*BCD_W +: BCD_W] = BCD_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_chain_counter.sv
// ---------------------------------------------------------------------------
// bcd_chain_counter
// One player's NUM_DIGITS-digit decimal counter with ripple carry.
//   clk, d_clr  : clock, async active-high clear
//   clr         : synchronous clear, wins over inc
//   inc         : add one this cycle
//   saturate    : 1 = hold at all-nines, 0 = wrap to zero
//   value       : registered packed BCD, digit 0 = units
//   value_nxt   : what value would become if inc were taken this cycle
// ---------------------------------------------------------------------------
module bcd_chain_counter
    import score_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        d_clr,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        saturate,
    output logic [NUM_DIGITS*BCD_W-1:0] value,
    output logic [NUM_DIGITS*BCD_W-1:0] value_nxt
);

    logic [NUM_DIGITS*BCD_W-1:0] value_q;
    logic                        carry;

    // A digit rolls to zero when it is at (or, defensively, above) nine, so
    // no digit can ever leave the 0..9 range even from a corrupted state.
    always_comb begin
        value_nxt = value_q;
        carry     = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (value_q[d*BCD_W +: BCD_W] >= BCD_MAX) begin
                    value_nxt[d*BCD_W +: BCD_W] = '0;
                end else begin
                    value_nxt[d*BCD_W +: BCD_W] = value_q[d*BCD_W +: BCD_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        // Carry out of the top digit means we were at max score.
        if (carry && saturate) begin
            value_nxt = {NUM_DIGITS{BCD_MAX}};
        end
    end

    always_ff @(posedge clk or posedge d_clr) begin
        if (d_clr) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (inc) begin
            value_q <= value_nxt;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bcd_score_bank.sv
// ---------------------------------------------------------------------------
// bcd_score_bank
// Multi-player BCD score bank: synchronises raw point requests, detects
// rising edges, counts per player in BCD and flags the winning score.
//
// Build option: define SCORE_DEBOUNCE_EN to put a DEBOUNCE_CYCLES-long
// debouncer after the synchroniser in every channel.
//
// Ports:
//   clk        system clock
//   d_clr      async active-high clear of all state
//   inc        raw async point request per player (rising edge = +1)
//   restart    synchronous clear of scores and win state
//   score      packed BCD, player p digit d at [(p*NUM_DIGITS+d)*4 +: 4]
//   game_over  high while in OVER
//   winner     players whose score hit WIN_SCORE (multi-hot on a tie)
//   inc_pulse  one-cycle strobe per accepted increment
//
// state | meaning
// ------+------------------------------------------------------------
// PLAY  | counting accepted edges, watching for WIN_SCORE
// OVER  | someone won; edges ignored, score/winner frozen until restart
// ---------------------------------------------------------------------------
module bcd_score_bank
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int NUM_DIGITS      = 2,
    parameter int WIN_SCORE       = 11,
    parameter int SATURATE        = 0,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                                  clk,
    input  logic                                  d_clr,
    input  logic [NUM_PLAYERS-1:0]                inc,
    input  logic                                  restart,
    output logic [NUM_PLAYERS*NUM_DIGITS*BCD_W-1:0] score,
    output logic                                  game_over,
    output logic [NUM_PLAYERS-1:0]                winner,
    output logic [NUM_PLAYERS-1:0]                inc_pulse
);

    localparam int  CW     = NUM_DIGITS * BCD_W;
    localparam logic [MAX_DIGITS*BCD_W-1:0] WIN_BCD_ALL = dec_to_bcd(WIN_SCORE);
    localparam logic [CW-1:0] WIN_BCD = WIN_BCD_ALL[CW-1:0];
    localparam bit  WIN_EN = (WIN_SCORE != 0);
    localparam bit  SAT_EN = (SATURATE != 0);

    // Configuration sanity; checked in both builds so toggling the
    // debounce option never exposes a latent bad value.
    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
        $error("bcd_score_bank: NUM_PLAYERS out of range");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_score_bank: NUM_DIGITS out of range");
    end
    if (WIN_SCORE < 0 || WIN_SCORE > (10 ** NUM_DIGITS) - 1) begin : g_bad_win
        $error("bcd_score_bank: WIN_SCORE exceeds max score");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("bcd_score_bank: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [NUM_PLAYERS-1:0] s1, s2, s3;
    logic [NUM_PLAYERS-1:0] lvl;
    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] accept;
    logic [NUM_PLAYERS-1:0] win_hit;
    logic [CW-1:0]          cnt_nxt [NUM_PLAYERS];
    score_state_t           state;

    // restart deliberately leaves the input path alone so a press that is
    // already in flight is still seen once play resumes.
    always_ff @(posedge clk or posedge d_clr) begin
        if (d_clr) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= inc;
            s2 <= s1;
        end
    end

`ifdef SCORE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_db
        logic [DB_W-1:0] timer;

        // Down-counter restarts whenever the synchronised input agrees with
        // the filtered level; reaching zero while they still disagree means
        // the new level has held for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clk or posedge d_clr) begin
            if (d_clr) begin
                timer  <= '0;
                lvl[p] <= 1'b0;
            end else if (s2[p] == lvl[p]) begin
                timer  <= DB_LOAD;
            end else if (timer == '0) begin
                lvl[p] <= s2[p];
                timer  <= DB_LOAD;
            end else begin
                timer  <= timer - 1'b1;
            end
        end
    end
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or posedge d_clr) begin
        if (d_clr) begin
            s3 <= '0;
        end else begin
            s3 <= lvl;
        end
    end

    assign rise   = lvl & ~s3;
    assign accept = rise & {NUM_PLAYERS{state == PLAY}};

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        bcd_chain_counter #(
            .NUM_DIGITS (NUM_DIGITS)
        ) u_cnt (
            .clk       (clk),
            .d_clr     (d_clr),
            .clr       (restart),
            .inc       (accept[p]),
            .saturate  (SAT_EN),
            .value     (score[p*CW +: CW]),
            .value_nxt (cnt_nxt[p])
        );
    end

    always_comb begin
        win_hit = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            win_hit[p] = WIN_EN && accept[p] && (cnt_nxt[p] == WIN_BCD);
        end
    end

    always_ff @(posedge clk or posedge d_clr) begin
        if (d_clr) begin
            state     <= PLAY;
            game_over <= 1'b0;
            winner    <= '0;
            inc_pulse <= '0;
        end else if (restart) begin
            state     <= PLAY;
            game_over <= 1'b0;
            winner    <= '0;
            inc_pulse <= '0;
        end else begin
            case (state)
                PLAY: begin
                    inc_pulse <= accept;
                    if (|win_hit) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                        winner    <= win_hit;
                    end
                end
                OVER: begin
                    inc_pulse <= '0;
                end
                default: begin
                    state     <= PLAY;
                    inc_pulse <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_score_bank.sv
module tb_bcd_score_bank;

    localparam int NP   = 2;
    localparam int ND   = 2;
    localparam int NI   = 3;
    localparam int MAXS = 99;

    logic        clk = 1'b0;
    logic        d_clr;
    logic [1:0]  inc_v     [NI];
    logic        restart_v [NI];
    logic [15:0] score_o   [NI];
    logic        go_o      [NI];
    logic [1:0]  win_o     [NI];
    logic [1:0]  pulse_o   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // inst 0: WIN 11, wrap   inst 1: no win, wrap   inst 2: no win, saturate
    bcd_score_bank #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .WIN_SCORE(11), .SATURATE(0), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .d_clr(d_clr), .inc(inc_v[0]), .restart(restart_v[0]),
        .score(score_o[0]), .game_over(go_o[0]), .winner(win_o[0]), .inc_pulse(pulse_o[0]));
    bcd_score_bank #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .WIN_SCORE(0), .SATURATE(0), .DEBOUNCE_CYCLES(4)) dut_w (
        .clk(clk), .d_clr(d_clr), .inc(inc_v[1]), .restart(restart_v[1]),
        .score(score_o[1]), .game_over(go_o[1]), .winner(win_o[1]), .inc_pulse(pulse_o[1]));
    bcd_score_bank #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .WIN_SCORE(0), .SATURATE(1), .DEBOUNCE_CYCLES(4)) dut_s (
        .clk(clk), .d_clr(d_clr), .inc(inc_v[2]), .restart(restart_v[2]),
        .score(score_o[2]), .game_over(go_o[2]), .winner(win_o[2]), .inc_pulse(pulse_o[2]));

    // ---------------- reference model (integer scores) ----------------
    int         m_score [NI][NP];
    bit         m_over  [NI];
    logic [1:0] m_win   [NI];
    logic [1:0] m_pulse [NI];
    logic [1:0] m_prev  [NI];
    logic [1:0] m_ev1   [NI];
    logic [1:0] m_ev2   [NI];

    function automatic int win_of(int i);
        return (i == 0) ? 11 : 0;
    endfunction

    function automatic bit sat_of(int i);
        return (i == 2);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < NP; p++) m_score[i][p] = 0;
            m_over[i] = 0; m_win[i] = '0; m_pulse[i] = '0;
            m_prev[i] = '0; m_ev1[i] = '0; m_ev2[i] = '0;
        end
    endfunction

    // A rise in the sampled request takes effect two edges after it is seen.
    function automatic void model_edge();
        logic [1:0] due, hit;
        int ns;
        for (int i = 0; i < NI; i++) begin
            due       = m_ev1[i];
            m_ev1[i]  = m_ev2[i];
            m_ev2[i]  = inc_v[i] & ~m_prev[i];
            m_prev[i] = inc_v[i];
            if (restart_v[i]) begin
                for (int p = 0; p < NP; p++) m_score[i][p] = 0;
                m_over[i] = 0; m_win[i] = '0; m_pulse[i] = '0;
            end else if (m_over[i]) begin
                m_pulse[i] = '0;
            end else begin
                m_pulse[i] = due;
                hit = '0;
                for (int p = 0; p < NP; p++) begin
                    if (due[p]) begin
                        if (m_score[i][p] == MAXS) ns = sat_of(i) ? MAXS : 0;
                        else ns = m_score[i][p] + 1;
                        m_score[i][p] = ns;
                        if (win_of(i) != 0 && ns == win_of(i)) hit[p] = 1'b1;
                    end
                end
                if (hit != '0) begin
                    m_over[i] = 1; m_win[i] = hit;
                end
            end
        end
    endfunction

    function automatic logic [15:0] exp_bus(int i);
        logic [15:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            r[(p*ND+0)*4 +: 4] = 4'(m_score[i][p] % 10);
            r[(p*ND+1)*4 +: 4] = 4'((m_score[i][p] / 10) % 10);
        end
        return r;
    endfunction

    always @(posedge clk or posedge d_clr) begin
        if (d_clr) model_clear();
        else model_edge();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NI; i++) begin
            inc_v[i] = '0; restart_v[i] = 1'b0;
        end
        d_clr = 1'b1;
        tick(2);
        d_clr = 1'b0;
        tick(1);
    endtask

    task automatic edges(int i, logic [1:0] m, int n);
        for (int e = 0; e < n; e++) begin
            inc_v[i] = m; tick(1);
            inc_v[i] = '0; tick(1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if (score_o[i] !== 16'h0000) begin n_fail++; $display("FAIL reset_score inst%0d: got %h want 0000", i, score_o[i]); end
            n_checks++;
            if (go_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_game_over inst%0d: got %b want 0", i, go_o[i]); end
            n_checks++;
            if (win_o[i] !== 2'b00) begin n_fail++; $display("FAIL reset_winner inst%0d: got %b want 00", i, win_o[i]); end
            n_checks++;
            if (pulse_o[i] !== 2'b00) begin n_fail++; $display("FAIL reset_pulse inst%0d: got %b want 00", i, pulse_o[i]); end
        end
        do_reset();
    endtask

    task automatic test_single_pulse();
        int pulses;
        do_reset();
        inc_v[0] = 2'b01;
        tick(2);
        n_checks++;
        if (score_o[0] !== 16'h0000) begin n_fail++; $display("FAIL pulse_early inst0: got %h want 0000", score_o[0]); end
        tick(1);
        inc_v[0] = 2'b00;
        n_checks++;
        if (score_o[0] !== 16'h0001) begin n_fail++; $display("FAIL pulse_score inst0: got %h want 0001", score_o[0]); end
        n_checks++;
        if (pulse_o[0] !== 2'b01) begin n_fail++; $display("FAIL pulse_strobe inst0: got %b want 01", pulse_o[0]); end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1);
            if (pulse_o[0] != 2'b00) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL pulse_width inst0: got %0d extra strobes want 0", pulses); end
        n_checks++;
        if (score_o[0] !== 16'h0001) begin n_fail++; $display("FAIL pulse_hold inst0: got %h want 0001", score_o[0]); end
    endtask

    task automatic test_hold();
        int pulses;
        do_reset();
        pulses = 0;
        inc_v[0] = 2'b10;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (pulse_o[0][1]) pulses++;
        end
        inc_v[0] = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (pulse_o[0][1]) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL hold_pulses inst0: got %0d want 1", pulses); end
        n_checks++;
        if (score_o[0] !== 16'h0100) begin n_fail++; $display("FAIL hold_score inst0: got %h want 0100", score_o[0]); end
    endtask

    task automatic test_wrap_saturate();
        int sat_pulses;
        do_reset();
        sat_pulses = 0;
        for (int e = 0; e < 99; e++) begin
            inc_v[1] = 2'b01; inc_v[2] = 2'b01; tick(1);
            if (pulse_o[2][0]) sat_pulses++;
            inc_v[1] = 2'b00; inc_v[2] = 2'b00; tick(1);
            if (pulse_o[2][0]) sat_pulses++;
            for (int i = 1; i < NI; i++) begin
                n_checks++;
                if (score_o[i] !== exp_bus(i)) begin n_fail++; $display("FAIL wrap_track inst%0d edge%0d: got %h want %h", i, e, score_o[i], exp_bus(i)); end
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick(1);
            if (pulse_o[2][0]) sat_pulses++;
        end
        n_checks++;
        if (score_o[1] !== 16'h0099) begin n_fail++; $display("FAIL wrap_at99 inst1: got %h want 0099", score_o[1]); end
        n_checks++;
        if (score_o[2] !== 16'h0099) begin n_fail++; $display("FAIL sat_at99 inst2: got %h want 0099", score_o[2]); end
        inc_v[1] = 2'b01; inc_v[2] = 2'b01; tick(1);
        inc_v[1] = 2'b00; inc_v[2] = 2'b00; tick(2);
        if (pulse_o[2][0]) sat_pulses++;
        n_checks++;
        if (score_o[1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_to0 inst1: got %h want 0000", score_o[1]); end
        n_checks++;
        if (pulse_o[1] !== 2'b01) begin n_fail++; $display("FAIL wrap_pulse inst1: got %b want 01", pulse_o[1]); end
        n_checks++;
        if (score_o[2] !== 16'h0099) begin n_fail++; $display("FAIL sat_hold inst2: got %h want 0099", score_o[2]); end
        n_checks++;
        if (pulse_o[2] !== 2'b01) begin n_fail++; $display("FAIL sat_pulse inst2: got %b want 01", pulse_o[2]); end
        n_checks++;
        if (sat_pulses != 100) begin n_fail++; $display("FAIL sat_pulse_count inst2: got %0d want 100", sat_pulses); end
        n_checks++;
        if (go_o[1] !== 1'b0 || go_o[2] !== 1'b0) begin n_fail++; $display("FAIL nowin_game_over: got %b%b want 00", go_o[1], go_o[2]); end
    endtask

    task automatic test_win();
        int pulses;
        do_reset();
        edges(0, 2'b01, 10);
        tick(3);
        n_checks++;
        if (score_o[0] !== 16'h0010 || go_o[0] !== 1'b0) begin n_fail++; $display("FAIL win_pre inst0: got %h/%b want 0010/0", score_o[0], go_o[0]); end
        inc_v[0] = 2'b01; tick(1);
        inc_v[0] = 2'b00; tick(2);
        n_checks++;
        if (score_o[0] !== 16'h0011) begin n_fail++; $display("FAIL win_score inst0: got %h want 0011", score_o[0]); end
        n_checks++;
        if (go_o[0] !== 1'b1) begin n_fail++; $display("FAIL win_game_over inst0: got %b want 1", go_o[0]); end
        n_checks++;
        if (win_o[0] !== 2'b01) begin n_fail++; $display("FAIL win_winner inst0: got %b want 01", win_o[0]); end
        pulses = 0;
        for (int e = 0; e < 3; e++) begin
            inc_v[0] = 2'b11; tick(1); if (pulse_o[0] != 2'b00) pulses++;
            inc_v[0] = 2'b00; tick(1); if (pulse_o[0] != 2'b00) pulses++;
        end
        for (int c = 0; c < 3; c++) begin
            tick(1); if (pulse_o[0] != 2'b00) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL over_pulses inst0: got %0d want 0", pulses); end
        n_checks++;
        if (score_o[0] !== 16'h0011 || win_o[0] !== 2'b01) begin n_fail++; $display("FAIL over_hold inst0: got %h/%b want 0011/01", score_o[0], win_o[0]); end
        restart_v[0] = 1'b1; tick(1); restart_v[0] = 1'b0;
        n_checks++;
        if (score_o[0] !== 16'h0000 || go_o[0] !== 1'b0 || win_o[0] !== 2'b00) begin
            n_fail++; $display("FAIL restart_clear inst0: got %h/%b/%b want 0000/0/00", score_o[0], go_o[0], win_o[0]);
        end
        inc_v[0] = 2'b01; tick(1);
        inc_v[0] = 2'b00; tick(2);
        n_checks++;
        if (score_o[0] !== 16'h0001 || pulse_o[0] !== 2'b01) begin n_fail++; $display("FAIL restart_play inst0: got %h/%b want 0001/01", score_o[0], pulse_o[0]); end
    endtask

    task automatic test_tie();
        do_reset();
        edges(0, 2'b11, 10);
        tick(3);
        n_checks++;
        if (score_o[0] !== 16'h1010) begin n_fail++; $display("FAIL tie_pre inst0: got %h want 1010", score_o[0]); end
        inc_v[0] = 2'b11; tick(1);
        inc_v[0] = 2'b00; tick(2);
        n_checks++;
        if (score_o[0] !== 16'h1111) begin n_fail++; $display("FAIL tie_score inst0: got %h want 1111", score_o[0]); end
        n_checks++;
        if (win_o[0] !== 2'b11) begin n_fail++; $display("FAIL tie_winner inst0: got %b want 11", win_o[0]); end
        n_checks++;
        if (go_o[0] !== 1'b1) begin n_fail++; $display("FAIL tie_game_over inst0: got %b want 1", go_o[0]); end
    endtask

    task automatic test_async_clr();
        do_reset();
        edges(0, 2'b10, 5);
        edges(1, 2'b01, 3);
        inc_v[0] = 2'b01;
        tick(1);
        #2;
        d_clr = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (score_o[i] !== 16'h0000 || go_o[i] !== 1'b0 || win_o[i] !== 2'b00 || pulse_o[i] !== 2'b00) begin
                n_fail++; $display("FAIL async_clr inst%0d: got %h/%b/%b/%b want 0000/0/00/00", i, score_o[i], go_o[i], win_o[i], pulse_o[i]);
            end
        end
        tick(2);
        d_clr = 1'b0;
        tick(3);
        n_checks++;
        if (score_o[0] !== 16'h0001 || pulse_o[0] !== 2'b01) begin n_fail++; $display("FAIL clr_release inst0: got %h/%b want 0001/01", score_o[0], pulse_o[0]); end
        inc_v[0] = 2'b00;
        tick(3);
        n_checks++;
        if (score_o[0] !== exp_bus(0)) begin n_fail++; $display("FAIL clr_model inst0: got %h want %h", score_o[0], exp_bus(0)); end
    endtask

    task automatic test_random();
        int lim [NI];
        do_reset();
        lim[0] = 40; lim[1] = 400; lim[2] = 400;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                inc_v[i]     = 2'($urandom_range(0, 3));
                restart_v[i] = ($urandom_range(0, lim[i] - 1) == 0);
            end
            tick(1);
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if (score_o[i] !== exp_bus(i)) begin n_fail++; $display("FAIL rand_score inst%0d cyc%0d: got %h want %h", i, c, score_o[i], exp_bus(i)); end
                n_checks++;
                if (go_o[i] !== m_over[i]) begin n_fail++; $display("FAIL rand_game_over inst%0d cyc%0d: got %b want %b", i, c, go_o[i], m_over[i]); end
                n_checks++;
                if (win_o[i] !== m_win[i]) begin n_fail++; $display("FAIL rand_winner inst%0d cyc%0d: got %b want %b", i, c, win_o[i], m_win[i]); end
                n_checks++;
                if (pulse_o[i] !== m_pulse[i]) begin n_fail++; $display("FAIL rand_pulse inst%0d cyc%0d: got %b want %b", i, c, pulse_o[i], m_pulse[i]); end
            end
        end
        for (int i = 0; i < NI; i++) begin
            inc_v[i] = '0; restart_v[i] = 1'b0;
        end
    endtask

    initial begin
        d_clr = 1'b1;
        for (int i = 0; i < NI; i++) begin
            inc_v[i] = '0; restart_v[i] = 1'b0;
        end
        test_reset();
        test_single_pulse();
        test_hold();
        test_wrap_saturate();
        test_win();
        test_tie();
        test_async_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
